// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator dump stage.
// No logic of its own; combinational helpers only.
// Not applicable: carries no flow control.
package acc_pkg;

  localparam int ACC_IN_W  = 38;
  localparam int ACC_OUT_W = 20;

  typedef enum logic {
    ACC = 1'b0,
    RND = 1'b1
  } state_t;

  // Largest value representable in a w-bit two's complement word.
  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a w-bit two's complement word.
  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/acc_out_fifo.sv
// Synchronous FIFO holding rounded samples for the output bus.
// Write visible on dout/empty the cycle after push; pop takes effect at the clock edge.
// Push on full is dropped (drop pulses) unless a pop happens in the same cycle.
module acc_out_fifo #(
  parameter int W     = 21,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  // Idle output is forced to zero so nothing stale shows while empty.
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage array; contents only matter behind valid pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/acc_dump_round_sat.sv
// Dumps the accumulator sum every DUMP_LEN samples or on flush; rounds, scales, saturates, queues.
// Trigger to clear_o is 1 cycle; trigger to valid_o is 2 cycles when the queue was empty.
// Output holds while valid_o && !ready_i; a dump arriving on a full queue is dropped, overflow_o sticks.
module acc_dump_round_sat
  import acc_pkg::*;
#(
  parameter int IN_W       = ACC_IN_W,
  parameter int OUT_W      = ACC_OUT_W,
  parameter int SHIFT      = 8,
  parameter int DUMP_LEN   = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = $clog2(DUMP_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  p_i,
  input  logic             p_valid_i,
  input  logic             flush_i,
  output logic [OUT_W-1:0] data_o,
  output logic             sat_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             clear_o,
  output logic             overflow_o,
  output logic [CW-1:0]    count_o
);

  localparam logic [CW-1:0]      LAST    = CW'(DUMP_LEN - 1);
  localparam logic signed [IN_W:0] RND_ADD = (IN_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [IN_W:0] SAT_HI  = (IN_W+1)'(sat_max(OUT_W));
  localparam logic signed [IN_W:0] SAT_LO  = (IN_W+1)'(sat_min(OUT_W));

  state_t             state_q;
  state_t             state_d;
  logic [CW-1:0]      count_q;
  logic [IN_W-1:0]    cap_q;
  logic               clear_q;
  logic               overflow_q;
  logic               trig;
  logic               push;
  logic signed [IN_W:0] r_ext;
  logic signed [IN_W:0] r;
  logic signed [IN_W:0] s;
  logic [OUT_W-1:0]   res_dat;
  logic               res_sat;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_drop;

  // The sample arriving with flush belongs to the window being dumped.
  assign trig = (p_valid_i && (count_q == LAST)) ||
                (flush_i && ((count_q != '0) || p_valid_i));

  // Window counter and capture of the post-update sum at the trigger.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      cap_q   <= '0;
      clear_q <= 1'b0;
    end else begin
      clear_q <= trig;
      if (trig) begin
        count_q <= '0;
        cap_q   <= p_i;
      end else if (p_valid_i) begin
        count_q <= count_q + CW'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ACC;
    else        state_q <= state_d;
  end

  // Next state and queue write; RND lasts one cycle unless a new dump lands back-to-back.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      ACC: if (trig) state_d = RND;
      RND: begin
        push    = 1'b1;
        state_d = trig ? RND : ACC;
      end
      default: state_d = ACC;
    endcase
  end

  // Round half toward +inf, arithmetic shift, then clip to the output range.
  always_comb begin
    r_ext   = {cap_q[IN_W-1], cap_q};
    r       = r_ext + RND_ADD;
    s       = r >>> SHIFT;
    res_dat = s[OUT_W-1:0];
    res_sat = 1'b0;
    if (s > SAT_HI) begin
      res_dat = SAT_HI[OUT_W-1:0];
      res_sat = 1'b1;
    end else if (s < SAT_LO) begin
      res_dat = SAT_LO[OUT_W-1:0];
      res_sat = 1'b1;
    end
  end

  acc_out_fifo #(
    .W     (OUT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({res_sat, res_dat}),
    .pop   (valid_o && ready_i),
    .dout  ({sat_o, data_o}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  // Sticky record that a dump was lost to a full queue.
  always_ff @(posedge clk) begin
    if (!reset) overflow_q <= 1'b0;
    else if (fifo_drop) overflow_q <= 1'b1;
  end

  assign valid_o    = !fifo_empty;
  assign clear_o    = clear_q;
  assign overflow_o = overflow_q;
  assign count_o    = count_q;

endmodule

// File: tb/tb_acc_dump_round_sat.sv
module tb_acc_dump_round_sat;

  logic        clk;
  logic        reset;
  logic [37:0] p_i;
  logic        p_valid_i;
  logic        flush_i;
  logic [19:0] data_o;
  logic        sat_o;
  logic        valid_o;
  logic        ready_i;
  logic        clear_o;
  logic        overflow_o;
  logic [2:0]  count_o;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  acc_dump_round_sat #(
    .IN_W(38), .OUT_W(20), .SHIFT(8), .DUMP_LEN(4), .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .p_i        (p_i),
    .p_valid_i  (p_valid_i),
    .flush_i    (flush_i),
    .data_o     (data_o),
    .sat_o      (sat_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .clear_o    (clear_o),
    .overflow_o (overflow_o),
    .count_o    (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input int exp_v, input logic exp_sat);
    logic [19:0] e;
    e = exp_v[19:0];
    chk({tag, ".valid"}, {31'd0, valid_o}, 32'd1);
    chk({tag, ".data"}, {12'd0, data_o}, {12'd0, e});
    chk({tag, ".sat"}, {31'd0, sat_o}, {31'd0, exp_sat});
  endtask

  // Four qualified samples; returns in the cycle after the trigger.
  task automatic send_window(input logic [37:0] last);
    p_valid_i = 1'b1;
    p_i = '0;
    for (int k = 0; k < 3; k++) tick();
    p_i = last;
    tick();
    p_valid_i = 1'b0;
    p_i = '0;
  endtask

  // One window through to the queue head, checked, then popped.
  task automatic dump_check(input string tag, input logic [37:0] last, input int exp_v, input logic exp_sat);
    ready_i = 1'b0;
    send_window(last);
    tick();
    chk_d(tag, exp_v, exp_sat);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk({tag, ".popped"}, {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    logic [63:0] rnd;
    reset = 1'b0; p_i = '0; p_valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;

    // 1: reset with random inputs
    for (int k = 0; k < 2; k++) begin
      rnd = {$urandom(), $urandom()};
      p_i = rnd[37:0];
      p_valid_i = rnd[40];
      flush_i = rnd[41];
      ready_i = rnd[42];
      tick();
    end
    chk("rst.valid", {31'd0, valid_o}, 32'd0);
    chk("rst.data", {12'd0, data_o}, 32'd0);
    chk("rst.sat", {31'd0, sat_o}, 32'd0);
    chk("rst.clear", {31'd0, clear_o}, 32'd0);
    chk("rst.ovf", {31'd0, overflow_o}, 32'd0);
    chk("rst.count", {29'd0, count_o}, 32'd0);
    p_i = '0; p_valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
    reset = 1'b1;
    tick();
    chk("rel.clear", {31'd0, clear_o}, 32'd0);
    chk("rel.count", {29'd0, count_o}, 32'd0);

    // 2: basic window, latency
    p_valid_i = 1'b1;
    tick(); tick();
    chk("win.count2", {29'd0, count_o}, 32'd2);
    tick();
    chk("win.count3", {29'd0, count_o}, 32'd3);
    p_i = 38'd768;
    tick();
    p_valid_i = 1'b0; p_i = '0;
    chk("win.clear", {31'd0, clear_o}, 32'd1);
    chk("win.count0", {29'd0, count_o}, 32'd0);
    chk("win.novalid", {31'd0, valid_o}, 32'd0);
    tick();
    chk("win.clear_off", {31'd0, clear_o}, 32'd0);
    chk_d("win", 3, 1'b0);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("win.popped", {31'd0, valid_o}, 32'd0);

    // 3: rounding
    dump_check("rnd384", 38'd384, 2, 1'b0);
    dump_check("rndm384", -38'sd384, -1, 1'b0);
    dump_check("rndm385", -38'sd385, -2, 1'b0);
    dump_check("rnd127", 38'd127, 0, 1'b0);

    // 4: saturation
    dump_check("satpos", 38'h1F_FFFF_FFFF, 524287, 1'b1);
    dump_check("satneg", 38'h20_0000_0000, -524288, 1'b1);

    // 5: overflow on full queue, then ordered drain
    ready_i = 1'b0;
    for (int k = 1; k <= 4; k++) send_window(38'(k * 256));
    tick();
    chk("ovf.before", {31'd0, overflow_o}, 32'd0);
    send_window(38'd1280);
    tick();
    chk("ovf.set", {31'd0, overflow_o}, 32'd1);
    ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk_d($sformatf("drain%0d", k), k, 1'b0);
      tick();
    end
    ready_i = 1'b0;
    chk("drain.empty", {31'd0, valid_o}, 32'd0);
    chk("drain.ovf", {31'd0, overflow_o}, 32'd1);

    // 6: flush after two samples
    p_valid_i = 1'b1;
    tick(); tick();
    p_valid_i = 1'b0; flush_i = 1'b1; p_i = 38'd1280;
    tick();
    flush_i = 1'b0; p_i = '0;
    chk("flush.clear", {31'd0, clear_o}, 32'd1);
    chk("flush.count", {29'd0, count_o}, 32'd0);
    tick();
    chk_d("flush", 5, 1'b0);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;

    // flush on empty window is ignored
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush0.clear", {31'd0, clear_o}, 32'd0);
    tick();
    chk("flush0.valid", {31'd0, valid_o}, 32'd0);

    // reset while the dump is being rounded
    send_window(38'd768);
    reset = 1'b0;
    tick();
    chk("rstrnd.valid", {31'd0, valid_o}, 32'd0);
    chk("rstrnd.clear", {31'd0, clear_o}, 32'd0);
    chk("rstrnd.ovf", {31'd0, overflow_o}, 32'd0);
    reset = 1'b1;
    tick();
    tick();
    chk("rstrnd.after", {31'd0, valid_o}, 32'd0);
    chk("rstrnd.count", {29'd0, count_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
